// File: rtl/thor2023_icache_fill.sv
// Instruction-cache line fill engine: bursts a line over the wishbone command bus, retries on rty/timeout,
// aborts on a foreign snoop. Define THOR2023_ICACHE_FILL_RR_EN for round-robin victim selection (default: LFSR).
package thor2023_icache_fill_pkg;
  typedef logic [31:0] wb_address_t;
  typedef enum logic [3:0] {CMD_NONE, CMD_LOAD, CMD_STORE, CMD_ICACHE_LOAD} wb_cmd_t;
  typedef enum logic [1:0] {LINEAR, WRAP4, WRAP8, WRAP16} wb_bte_t;
  typedef enum logic [2:0] {CLASSIC, FIXED, INCR, EOB = 3'd7} wb_cti_t;
  typedef enum logic [3:0] {NON_CACHEABLE = 4'd0, CACHEABLE = 4'd15} wb_cache_t;
  typedef enum logic [3:0] {DATA = 4'd0, STACK = 4'd1, CODE = 4'd2} wb_seg_t;

  typedef struct packed {
    wb_cmd_t      cmd;
    logic [5:0]   blen;
    wb_bte_t      bte;
    wb_cti_t      cti;
    logic [3:0]   cid;
    logic [7:0]   tid;
    logic [3:0]   pri;
    wb_cache_t    cache;
    wb_seg_t      seg;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    wb_address_t  vadr;
    wb_address_t  padr;
    logic [127:0] dat;
  } wb_cmd_request128_t;

  typedef struct packed {
    logic         ack;
    logic         rty;
    logic         next;
    wb_address_t  adr;
    logic [127:0] dat;
  } wb_cmd_response128_t;
endpackage

module thor2023_icache_fill
  import thor2023_icache_fill_pkg::*;
#(
  parameter int         WAYS    = 4,
  parameter int         BEATS   = 2,
  parameter logic [3:0] CID     = 4'd2,
  parameter int         CORENO  = 1,
  parameter int         TO_BITS = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  output wb_cmd_request128_t         wbm_req,
  input  wb_cmd_response128_t        wbm_resp,
  input  logic                       hit,
  input  wb_address_t                miss_adr,
  input  wb_address_t                snoop_adr,
  input  logic                       snoop_v,
  input  logic [3:0]                 snoop_cid,
  output logic                       wr_ic,
  output logic [$clog2(WAYS)-1:0]    way,
  output wb_address_t                line_vtag,
  output wb_address_t                line_ptag,
  output logic [BEATS*128-1:0]       line_data,
  output logic [BEATS-1:0]           line_v,
  output logic                       busy
);
  localparam int LOG_BEATS = $clog2(BEATS);
  localparam int LOG_LINE  = $clog2(BEATS*16);
  localparam int WAYW      = $clog2(WAYS);
  localparam int IDX_HI    = 12;  // set index lives between the line offset and the 4 KiB page boundary
  localparam wb_address_t LINE_MASK = ~wb_address_t'(BEATS*16-1);
  localparam logic [LOG_BEATS:0] LAST_NXT = (LOG_BEATS+1)'(BEATS-1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, BACKOFF, WRITE, SETTLE1, SETTLE2} state_t;

  state_t               state;
  logic [16:0]          lfsr;
  logic [2:0]           seq;
  logic [TO_BITS-1:0]   to_cnt;
  logic [LOG_BEATS:0]   nxt_cnt;
  logic [LOG_BEATS-1:0] beat;
  logic                 snoop_hit;
  logic                 unused_bits;
`ifdef THOR2023_ICACHE_FILL_RR_EN
  logic [WAYW-1:0]      rr_ptr;
`endif

  assign beat      = wbm_resp.adr[4 +: LOG_BEATS];
  assign snoop_hit = snoop_v && (snoop_cid != CID) && (state != IDLE) &&
                     (snoop_adr[IDX_HI-1:LOG_LINE] == miss_adr[IDX_HI-1:LOG_LINE]);
  assign busy      = (state != IDLE);
  assign unused_bits = ^{wbm_resp.adr, snoop_adr};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wbm_req       <= '0;
      wbm_req.pri   <= 4'h7;
      wbm_req.cid   <= 4'd7;
      wbm_req.cache <= CACHEABLE;
      wbm_req.seg   <= CODE;
      wbm_req.bte   <= LINEAR;
      wbm_req.cti   <= CLASSIC;
      wr_ic         <= 1'b0;
      way           <= '0;
      line_v        <= '0;
      line_data     <= '0;
      line_vtag     <= '0;
      line_ptag     <= '0;
      seq           <= '0;
      to_cnt        <= '0;
      nxt_cnt       <= '0;
      lfsr          <= 17'h1;
`ifdef THOR2023_ICACHE_FILL_RR_EN
      rr_ptr        <= '0;
`endif
    end else begin
      lfsr  <= {lfsr[15:0], lfsr[16] ^ lfsr[13]};
      wr_ic <= 1'b0;
      if (snoop_hit) begin
        // another agent touched this set mid-fill: drop everything, nothing is written
        wbm_req.cyc <= 1'b0;
        wbm_req.stb <= 1'b0;
        wbm_req.sel <= '0;
        line_v      <= '0;
        state       <= IDLE;
      end else begin
        case (state)
          IDLE: if (!hit) state <= REQ;
          REQ: begin
            wbm_req.cyc  <= 1'b1;
            wbm_req.stb  <= 1'b1;
            wbm_req.we   <= 1'b0;
            wbm_req.sel  <= 16'hFFFF;
            wbm_req.cmd  <= CMD_ICACHE_LOAD;
            wbm_req.blen <= 6'(BEATS-1);
            wbm_req.vadr <= miss_adr & LINE_MASK;
            wbm_req.padr <= miss_adr & LINE_MASK;
            wbm_req.tid  <= {4'(CORENO), 1'b0, seq};
            seq          <= seq + 3'd1;
            line_v       <= '0;
            to_cnt       <= '0;
            nxt_cnt      <= '0;
            state        <= WAIT;
          end
          WAIT: begin
            if (wbm_resp.rty) begin
              wbm_req.cyc <= 1'b0;
              wbm_req.stb <= 1'b0;
              wbm_req.sel <= '0;
              line_v      <= '0;
              state       <= BACKOFF;
            end else if (&line_v) begin
              wbm_req.cyc <= 1'b0;
              wbm_req.stb <= 1'b0;
              wbm_req.sel <= '0;
              state       <= WRITE;
            end else begin
              if (wbm_resp.ack) begin
                line_data[{beat, 7'd0} +: 128] <= wbm_resp.dat;
                line_v[beat] <= 1'b1;
                to_cnt       <= '0;
              end else if (&to_cnt) begin
                wbm_req.cyc <= 1'b0;
                wbm_req.stb <= 1'b0;
                wbm_req.sel <= '0;
                state       <= BACKOFF;
              end else begin
                to_cnt <= to_cnt + TO_BITS'(1);
              end
              if (wbm_resp.next && nxt_cnt < LAST_NXT) begin
                if (nxt_cnt == '0) begin
                  line_vtag <= wbm_req.vadr & LINE_MASK;
                  line_ptag <= wbm_req.padr & LINE_MASK;
                end
                wbm_req.vadr <= wbm_req.vadr + 32'd16;
                wbm_req.padr <= wbm_req.padr + 32'd16;
                nxt_cnt      <= nxt_cnt + (LOG_BEATS+1)'(1);
              end
            end
          end
          BACKOFF: if (lfsr[4:2] == 3'b111) state <= REQ;
          WRITE: begin
            wr_ic <= &line_v;
`ifdef THOR2023_ICACHE_FILL_RR_EN
            way    <= rr_ptr;
            rr_ptr <= rr_ptr + WAYW'(1);
`else
            way    <= lfsr[WAYW-1:0];
`endif
            state  <= SETTLE1;
          end
          SETTLE1: if (!wbm_resp.ack) state <= SETTLE2;
          SETTLE2: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_thor2023_icache_fill.sv
// Randomized bench for thor2023_icache_fill (BEATS=4): scoreboard of beats per line, tid sequence and victim ways.
module tb_thor2023_icache_fill;
  import thor2023_icache_fill_pkg::*;
  localparam int         BEATS = 4, WAYS = 4, CORENO = 1, TO_BITS = 5;
  localparam logic [3:0] CID = 4'd2;
  localparam int         LW = BEATS*128;

  logic clk = 1'b0, rst = 1'b1, hit = 1'b1, snoop_v = 1'b0, wr_ic, busy;
  wb_cmd_request128_t  wbm_req;
  wb_cmd_response128_t resp;
  wb_address_t miss_adr, snoop_adr, line_vtag, line_ptag, aligned;
  logic [3:0]  snoop_cid;
  logic [1:0]  way;
  logic [LW-1:0]    line_data;
  logic [BEATS-1:0] line_v, mv;
  logic [127:0]     mdl [BEATS];
  int errs = 0, checks = 0, seq_exp = 0, rr_exp = 0;

  thor2023_icache_fill #(.WAYS(WAYS), .BEATS(BEATS), .CID(CID), .CORENO(CORENO), .TO_BITS(TO_BITS)) dut (
    .clk(clk), .rst(rst), .wbm_req(wbm_req), .wbm_resp(resp), .hit(hit), .miss_adr(miss_adr),
    .snoop_adr(snoop_adr), .snoop_v(snoop_v), .snoop_cid(snoop_cid), .wr_ic(wr_ic), .way(way),
    .line_vtag(line_vtag), .line_ptag(line_ptag), .line_data(line_data), .line_v(line_v), .busy(busy));

  always #5 clk = ~clk;
  initial begin #500000; $display("FAIL watchdog: sim time limit hit"); $fatal(1); end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    if (obs !== exp) begin errs++; $display("FAIL %s: got %0h want %0h", tag, obs, exp); end
  endtask

  task automatic tick; @(posedge clk); #1; endtask

  task automatic wait_cyc(input int lim, output bit ok, output bit saw_wr, output int n);
    ok = 0; saw_wr = 0; n = 0;
    for (int i = 0; i < lim; i++) begin
      tick(); n++;
      if (wr_ic) saw_wr = 1;
      if (wbm_req.cyc) begin ok = 1; break; end
    end
  endtask

  task automatic check_req;
    chk("req_tid",  wbm_req.tid, {4'(CORENO), 1'b0, 3'(seq_exp)});
    seq_exp = (seq_exp + 1) % 8;
    chk("req_blen", wbm_req.blen, BEATS-1);
    chk("req_sel",  wbm_req.sel, 16'hFFFF);
    chk("req_we",   wbm_req.we, 0);
    chk("req_stb",  wbm_req.stb, 1);
    chk("req_cmd",  wbm_req.cmd, CMD_ICACHE_LOAD);
    chk("req_vadr", wbm_req.vadr, aligned);
    chk("req_padr", wbm_req.padr, aligned);
  endtask

  task automatic send_beat(input int idx, input bit nxt);
    resp.ack = 1; resp.next = nxt;
    resp.adr = aligned + 32'(idx*16) + $urandom_range(0, 15);
    resp.dat = {$urandom(), $urandom(), $urandom(), $urandom()};
    mdl[idx] = resp.dat; mv[idx] = 1'b1;
    tick();
    resp.ack = 0; resp.next = 0;
    chk("line_v", line_v, mv);
  endtask

  // idle cycles between beats, sometimes carrying a snoop that must be ignored
  task automatic gap;
    repeat ($urandom_range(0, 3)) begin
      if ($urandom_range(0, 2) == 0) begin
        snoop_v = 1;
        if ($urandom_range(0, 1) == 0) begin
          snoop_cid = CID; snoop_adr = miss_adr ^ ($urandom() & 32'hFFFF_F03F);
        end else begin
          snoop_cid = 4'd3; snoop_adr = miss_adr ^ (32'h1 << $urandom_range(6, 11));
        end
      end
      tick();
      snoop_v = 0;
      chk("gap_cyc", wbm_req.cyc, 1);
    end
  endtask

  task automatic data_phase;
    int ord[BEATS]; int q[$]; int j, t, nacks;
    logic [LW-1:0] exp_line;
    for (int i = 0; i < BEATS; i++) ord[i] = i;
    for (int i = BEATS-1; i > 0; i--) begin
      j = $urandom_range(0, i); t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    for (int i = 0; i < BEATS; i++) q.push_back(ord[i]);
    if ($urandom_range(0, 2) == 0) q.insert(BEATS-1, ord[$urandom_range(0, BEATS-2)]);
    nacks = 0;
    foreach (q[k]) begin
      gap();
      send_beat(q[k], nacks < BEATS-1);
      nacks++;
    end
    for (int i = 0; i < BEATS; i++) exp_line[i*128 +: 128] = mdl[i];
    chk("full_cyc_still", wbm_req.cyc, 1);
    tick();
    chk("drop_cyc", wbm_req.cyc, 0);
    chk("drop_sel", wbm_req.sel, 0);
    chk("drop_wr",  wr_ic, 0);
    tick();
    chk("wr_ic",      wr_ic, 1);
    chk("line_data",  line_data, exp_line);
    chk("line_vtag",  line_vtag, aligned);
    chk("line_ptag",  line_ptag, aligned);
`ifdef THOR2023_ICACHE_FILL_RR_EN
    chk("way_rr", way, 2'(rr_exp));
    rr_exp = (rr_exp + 1) % WAYS;
`endif
    tick();
    chk("wr_ic_pulse", wr_ic, 0);
    chk("settle_busy", busy, 1);
    tick();
    chk("idle_busy", busy, 0);
  endtask

  // kind: 0 clean fill, 1 rty first beat, 2 response timeout, 3 snoop abort
  task automatic do_fill(input int kind);
    bit ok, sw; int n;
    miss_adr = $urandom(); aligned = miss_adr & ~32'(BEATS*16-1);
    mv = '0; hit = 0;
    wait_cyc(20, ok, sw, n);
    chk("req_seen", ok, 1);
    if (!ok) return;
    hit = 1;
    check_req();
    if (kind == 1 || kind == 2) begin
      if (kind == 1) begin
        resp.rty = 1; resp.ack = 1'($urandom_range(0, 1));
        resp.adr = aligned; resp.dat = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        resp.rty = 0; resp.ack = 0;
        chk("rty_cyc", wbm_req.cyc, 0);
        chk("rty_line_v", line_v, 0);
        chk("rty_busy", busy, 1);
      end else begin
        n = 0;
        while (wbm_req.cyc && n < 40) begin tick(); n++; end
        chk("timeout_len", (n >= 31 && n <= 33), 1);
      end
      wait_cyc(600, ok, sw, n);
      chk("retry_seen", ok, 1);
      chk("retry_no_wr", sw, 0);
      chk("backoff_min", n >= 2, 1);
      if (!ok) return;
      check_req();
      data_phase();
    end else if (kind == 3) begin
      send_beat($urandom_range(0, BEATS-1), 1'b1);
      snoop_v = 1; snoop_cid = 4'd3; snoop_adr = miss_adr ^ ($urandom() & 32'hFFFF_F03F);
      tick();
      snoop_v = 0;
      chk("snoop_cyc", wbm_req.cyc, 0);
      chk("snoop_busy", busy, 0);
      chk("snoop_line_v", line_v, 0);
      repeat (4) begin
        tick();
        chk("snoop_no_wr", wr_ic, 0);
        chk("snoop_idle", busy, 0);
      end
    end else begin
      data_phase();
    end
  endtask

  initial begin
    bit ok, sw; int n;
    resp = '0; miss_adr = '0; snoop_adr = '0; snoop_cid = '0;
    repeat (3) tick();
    chk("rst_cyc", wbm_req.cyc, 0);
    chk("rst_stb", wbm_req.stb, 0);
    chk("rst_sel", wbm_req.sel, 0);
    chk("rst_tid", wbm_req.tid, 0);
    chk("rst_pri", wbm_req.pri, 4'h7);
    chk("rst_cid", wbm_req.cid, 4'd7);
    chk("rst_cache", wbm_req.cache, CACHEABLE);
    chk("rst_seg", wbm_req.seg, CODE);
    chk("rst_bte", wbm_req.bte, LINEAR);
    chk("rst_cti", wbm_req.cti, CLASSIC);
    chk("rst_wr", wr_ic, 0);
    chk("rst_way", way, 0);
    chk("rst_line_v", line_v, 0);
    chk("rst_data", line_data, 0);
    chk("rst_vtag", line_vtag, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    tick();
    for (int f = 0; f < 16; f++) do_fill(f < 4 ? f : int'($urandom_range(0, 3)));

    // reset in the middle of a burst, then a stray ack that must be ignored
    miss_adr = $urandom(); aligned = miss_adr & ~32'(BEATS*16-1); hit = 0;
    wait_cyc(20, ok, sw, n);
    chk("mid_req_seen", ok, 1);
    hit = 1; rst = 1;
    tick();
    chk("mid_rst_cyc", wbm_req.cyc, 0);
    rst = 0; resp.ack = 1; resp.adr = aligned;
    tick(); tick();
    resp.ack = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_line_v", line_v, 0);
    chk("mid_rst_wr", wr_ic, 0);
    seq_exp = 0; rr_exp = 0;
    do_fill(0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
